// File: rtl/op_seq_pkg.sv
// Shared types and defaults for the op_sequencer transaction engine.
package op_seq_pkg;

  typedef enum logic [2:0] {
    INIT,
    WARM,
    IDLE,
    START,
    RUN,
    DONE,
    STATUS
  } op_state_t;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_STOP = 2'b01,
    ST_ERR  = 2'b10
  } op_status_t;

  localparam int RT_CYCLES_DEF  = 4;
  localparam int ENABLE_DLY_DEF = 3;

endpackage

// File: rtl/op_seq_init.sv
// Power-up sequencer: rt after reset, then a settle delay before enable.
module op_seq_init
  import op_seq_pkg::*;
#(
  parameter int RT_CYCLES  = RT_CYCLES_DEF,
  parameter int ENABLE_DLY = ENABLE_DLY_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rt,
  output logic o_enable,
  output logic o_init_done
);

  localparam int CNT_MAX = RT_CYCLES + ENABLE_DLY + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // saturating count of edges since reset release
  assign w_cnt_nxt = (r_cnt == CW'(CNT_MAX)) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      o_rt        <= 1'b1;
      o_enable    <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      o_rt        <= (w_cnt_nxt <= CW'(RT_CYCLES));
      o_enable    <= (w_cnt_nxt >= CW'(CNT_MAX));
      // one cycle early so the FSM reaches IDLE together with enable
      o_init_done <= (w_cnt_nxt >= CW'(CNT_MAX - 1));
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Transaction engine: power-up, request accept, timed run, end/abort/fault.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int RT_CYCLES  = RT_CYCLES_DEF,
  parameter int ENABLE_DLY = ENABLE_DLY_DEF,
  parameter bit IRQ_EN     = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_fault,
  output logic             o_ack,
  output logic             o_rt,
  output logic             o_enable,
  output logic             o_start,
  output logic             o_rdy,
  output logic             o_endd,
  output logic             o_stop,
  output logic             o_er,
  output logic             o_interrupt,
  output logic             o_status_valid,
  output logic [1:0]       o_status
);

  op_state_t  r_state, w_state_nxt;
  op_status_t r_term, w_term_nxt;
  op_status_t r_status;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic w_init_done;
  logic w_ack, w_done, w_sv;

  op_seq_init #(
    .RT_CYCLES  (RT_CYCLES),
    .ENABLE_DLY (ENABLE_DLY)
  ) u_init (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_rt        (o_rt),
    .o_enable    (o_enable),
    .o_init_done (w_init_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_term_nxt  = r_term;
    w_cnt_nxt   = r_cnt;
    w_ack       = 1'b0;
    w_done      = 1'b0;
    w_sv        = 1'b0;
    unique case (r_state)
      INIT: if (!o_rt) w_state_nxt = WARM;
      WARM: if (w_init_done) w_state_nxt = IDLE;
      IDLE: begin
        if (i_req) begin
          w_state_nxt = START;
          w_ack       = 1'b1;
          w_cnt_nxt   = (i_len == '0) ? '0 : i_len - LEN_W'(1);
        end
      end
      START, RUN: begin
        if (i_fault) begin
          w_state_nxt = DONE;
          w_term_nxt  = ST_ERR;
          w_done      = 1'b1;
        end else if (i_abort) begin
          w_state_nxt = DONE;
          w_term_nxt  = ST_STOP;
          w_done      = 1'b1;
        end else if (r_state == RUN && r_cnt == '0) begin
          w_state_nxt = DONE;
          w_term_nxt  = ST_OK;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = RUN;
          if (r_state == RUN) w_cnt_nxt = r_cnt - LEN_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = STATUS;
        w_sv        = 1'b1;
      end
      STATUS: w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= INIT;
      r_term         <= ST_OK;
      r_status       <= ST_OK;
      r_cnt          <= '0;
      o_ack          <= 1'b0;
      o_start        <= 1'b0;
      o_rdy          <= 1'b0;
      o_endd         <= 1'b0;
      o_stop         <= 1'b0;
      o_er           <= 1'b0;
      o_interrupt    <= 1'b0;
      o_status_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_term         <= w_term_nxt;
      r_cnt          <= w_cnt_nxt;
      o_ack          <= w_ack;
      o_start        <= w_ack;
      o_rdy          <= w_done;
      o_endd         <= w_done && (w_term_nxt == ST_OK);
      o_stop         <= w_done && (w_term_nxt == ST_STOP);
      o_er           <= w_done && (w_term_nxt == ST_ERR);
      o_interrupt    <= w_done && IRQ_EN;
      o_status_valid <= w_sv;
      if (w_sv) r_status <= r_term;
    end
  end

  assign o_status = r_status;

endmodule
